imgproc_axil_regbank: RTL and testbench
=======================================

Name: imgproc_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank for the image-processor IP, the successor to the fixed four-register S00_AXI slave. It adds:
- configurable register count;
- byte-strobe writes;
- per-register read-only mapping to hardware inputs;
- a write-1-to-clear status register fed by hardware events;
- SLVERR on out-of-range addresses.

It sits between the block-design AXI interconnect and the pixel-pipeline control logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; 32 only (checked by elaboration assertion)
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUM_REGS
NUM_REGS, 16, number of 32-bit registers, 4..64
RO_MASK, 'h0, NUM_REGS-bit mask; bit i set = register i is read-only and mirrors hw_ro_in
STATUS_IDX, NUM_REGS-1, index of the W1C status register

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_S_AXI_ADDR_WIDTH/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
reg_q  out  NUM_REGS*32  flattened current register contents; register i at [32i+:32]
reg_wr_stb  out  NUM_REGS  one-cycle pulse on the cycle after a committed write to register i
hw_ro_in  in  NUM_REGS*32  read-only sources; only slices selected by RO_MASK are used
hw_event  in  32  status set pulses, one per bit

Behaviour:
- Clock, reset and interface:
  - One clock, ACLK. ARESETN is synchronous and active-low.
  - While ARESETN=0, at each ACLK edge:
    - all registers, the status register and the holding slots clear;
    - AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr_stb are 0;
    - RDATA=0, BRESP=0, RRESP=0.
  - Reset asserted mid-transaction drops all pending state; no response is issued.
  - AWPROT/ARPROT are ignored.
- Write path:
  - AW and W are captured independently into one-entry holding slots. AWREADY = !aw_full and WREADY = !w_full, both registered.
  - Commit happens on the first edge where aw_full & w_full & !BVALID. At that edge:
    - the register updates;
    - both slots clear;
    - BVALID is set with BRESP.
  - Latency: AW and W handshaken at edge N gives commit and BVALID visible after edge N+1.
  - BVALID is held until BREADY; the next commit waits for the BVALID/BREADY handshake.
- Address decode:
  - idx = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - idx >= NUM_REGS gives RESP=2'b10 (SLVERR); no write happens and reads return 0.
- Write rules:
  - Byte lane k is written only if WSTRB[k] is set. WSTRB=0 gives OKAY with no change, but reg_wr_stb still pulses.
  - RO_MASK[idx] set: write ignored, OKAY, no reg_wr_stb.
  - STATUS_IDX: write-1-to-clear per strobed bit.
  - Each edge: status |= hw_event. When set and clear hit the same bit on the same edge, set wins.
- Read path:
  - ARREADY = !RVALID. On the ARVALID&ARREADY edge, RDATA/RRESP/RVALID are registered; RVALID is held until RREADY. One read is outstanding at a time.
  - Read of an RO register returns the hw_ro_in slice sampled at the AR handshake edge.
  - Read and commit to the same register on the same edge return the pre-write value.
  - Reads and writes proceed concurrently with no mutual stall.

Optional Feature:
- Macro: IMGPROC_REGBANK_IRQ_EN.
- Defined:
  - Register STATUS_IDX-1 becomes IRQ_ENABLE (RW, byte-strobed). Requires STATUS_IDX>=1 and STATUS_IDX-1 not in RO_MASK.
  - Adds output port irq (1 bit) = registered |(status & IRQ_ENABLE), so it is visible one edge after the contributing status/enable change.
  - irq resets to 0.
- Undefined: no irq port; register STATUS_IDX-1 is an ordinary RW register.

Decomposition:
- Package imgproc_regbank_pkg:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10);
  - REG_BYTES=4;
  - function idx_of(addr);
  - byte-strobe merge function apply_wstrb(old,new,strb).
- Sub-module imgproc_axil_slot: generic one-entry valid/ready holding register, parametrised payload width. Instantiated twice, for AW (addr) and W (data+strb).

Test Plan:
1. Reset then write 0x1..0x4 to byte addresses 0x0,0x4,0x8,0xC, read back -> RDATA 0x1..0x4, RRESP=OKAY, reg_wr_stb[0..3] each pulse once.
2. W presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF, WSTRB=4'b0101) over prior 0x11223344 -> BVALID 1 cycle after AW handshake, read 0x8 = 0x11AD33EF.
3. RO_MASK bit 2 set, hw_ro_in slice2=0xCAFE0001; write 0xFFFFFFFF to 0x8 -> BRESP OKAY, no stb, read = 0xCAFE0001.
4. hw_event=0x5 pulse; read status = 0x5; write 0x1 to status while hw_event=0x1 same edge -> status remains 0x5; next write 0x4 -> 0x1.
5. Write/read at address 0x3C with NUM_REGS=8 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no register change; BREADY held low 10 cycles -> BVALID stays 1, AWREADY stays 0 after next AW captured.
6. With IMGPROC_REGBANK_IRQ_EN: enable=0x4, hw_event bit2 pulse -> irq=1 one edge after status set; W1C bit2 -> irq=0 one edge later; reset mid-write (AW captured, W pending) -> no BVALID afterwards.

Source files
------------

// File: rtl/imgproc_regbank_pkg.sv
// Shared types and helpers for the image-processor AXI4-Lite register bank.
package imgproc_regbank_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    B_IDLE,
    B_RESP
  } b_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  localparam int unsigned REG_BYTES = 4;
  localparam int unsigned REG_BITS  = 8 * REG_BYTES;

  // Register index from a zero-extended byte address; the byte offset is dropped.
  function automatic int unsigned idx_of(input logic [63:0] addr);
    return 32'(addr >> $clog2(REG_BYTES));
  endfunction

  function automatic logic [REG_BITS-1:0] apply_wstrb(input logic [REG_BITS-1:0]  old_w,
                                                      input logic [REG_BITS-1:0]  new_w,
                                                      input logic [REG_BYTES-1:0] strb);
    logic [REG_BITS-1:0] res;
    res = old_w;
    for (int unsigned k = 0; k < REG_BYTES; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/imgproc_axil_regbank_if.sv
// AXI4-Lite bus bundle for the image-processor register bank.
interface imgproc_axil_regbank_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID,    input WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input RREADY
  );

endinterface

// File: rtl/imgproc_axil_slot.sv
// One-entry valid/ready holding register; ready is registered as !full.
module imgproc_axil_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic [WIDTH-1:0] data,
  input  logic             clr
);

  logic take;
  logic full_nxt;

  always_comb begin
    take     = in_valid && in_ready;
    full_nxt = full;
    if (clr)       full_nxt = 1'b0;
    else if (take) full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nxt;
      in_ready <= !full_nxt;
      if (take) data <= in_data;
    end
  end

endmodule

// File: rtl/imgproc_axil_regbank.sv
// Parametrised AXI4-Lite register bank: byte strobes, RO mirrors, W1C status, SLVERR decode.
// Optional irq output and IRQ_ENABLE register when IMGPROC_REGBANK_IRQ_EN is defined.
module imgproc_axil_regbank
  import imgproc_regbank_pkg::*;
#(
  parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned         NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter int unsigned         STATUS_IDX         = NUM_REGS - 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  imgproc_axil_regbank_if.slave        S_AXI,
  output logic [NUM_REGS*REG_BITS-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_stb,
  input  logic [NUM_REGS*REG_BITS-1:0] hw_ro_in,
  input  logic [REG_BITS-1:0]          hw_event
`ifdef IMGPROC_REGBANK_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned WW = REG_BITS + REG_BYTES;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("imgproc_axil_regbank: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 4 || NUM_REGS > 64) begin : g_bad_num_regs
    $error("imgproc_axil_regbank: NUM_REGS must be 4..64");
  end
  if ((1 << (AW - 2)) < NUM_REGS) begin : g_bad_addr_width
    $error("imgproc_axil_regbank: address width too small for NUM_REGS");
  end
  if (STATUS_IDX >= NUM_REGS) begin : g_bad_status_idx
    $error("imgproc_axil_regbank: STATUS_IDX out of range");
  end

  logic                 prot_unused;
  logic                 aw_full;
  logic                 w_full;
  logic [AW-1:0]        aw_addr;
  logic [WW-1:0]        w_payload;
  logic [REG_BITS-1:0]  w_data;
  logic [REG_BYTES-1:0] w_strb;
  logic [REG_BITS-1:0]  w_clr;
  logic                 commit;
  int unsigned          w_idx;
  resp_t                w_resp;
  logic [NUM_REGS-1:0]  wr_hit;

  b_state_t             b_state_q, b_state_d;
  resp_t                bresp_q, bresp_d;

  logic [REG_BITS-1:0]  regs_q [NUM_REGS];

  int unsigned          r_idx;
  logic [REG_BITS-1:0]  r_word;
  resp_t                r_resp;
  logic                 ar_hs;
  r_state_t             r_state_q, r_state_d;
  logic                 arready_q;
  logic [REG_BITS-1:0]  rdata_q;
  resp_t                rresp_q;

  assign prot_unused = ^{S_AXI.AWPROT, S_AXI.ARPROT};

  imgproc_axil_slot #(.WIDTH(AW)) u_aw_slot (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_valid (S_AXI.AWVALID),
    .in_ready (S_AXI.AWREADY),
    .in_data  (S_AXI.AWADDR),
    .full     (aw_full),
    .data     (aw_addr),
    .clr      (commit)
  );

  imgproc_axil_slot #(.WIDTH(WW)) u_w_slot (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_valid (S_AXI.WVALID),
    .in_ready (S_AXI.WREADY),
    .in_data  ({S_AXI.WSTRB, S_AXI.WDATA}),
    .full     (w_full),
    .data     (w_payload),
    .clr      (commit)
  );

  assign {w_strb, w_data} = w_payload;

  // Write commit waits for both slots and for the previous response to drain.
  always_comb begin
    commit = aw_full && w_full && (b_state_q == B_IDLE);
    w_idx  = idx_of(64'(aw_addr));
    w_resp = (w_idx < NUM_REGS) ? OKAY : SLVERR;
    w_clr  = apply_wstrb('0, w_data, w_strb);
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit && (w_idx == i) && !RO_MASK[i]) wr_hit[i] = 1'b1;
    end
  end

  always_comb begin
    b_state_d = b_state_q;
    bresp_d   = bresp_q;
    case (b_state_q)
      B_IDLE: if (commit) begin
        b_state_d = B_RESP;
        bresp_d   = w_resp;
      end
      B_RESP: if (S_AXI.BREADY) b_state_d = B_IDLE;
      default: b_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      b_state_q <= B_IDLE;
      bresp_q   <= OKAY;
    end else begin
      b_state_q <= b_state_d;
      bresp_q   <= bresp_d;
    end
  end

  assign S_AXI.BVALID = (b_state_q == B_RESP);
  assign S_AXI.BRESP  = bresp_q;

  // Status bits: hardware set is OR'd in after the W1C clear so set wins.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= wr_hit;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i == STATUS_IDX) begin
          regs_q[i] <= (regs_q[i] & ~(wr_hit[i] ? w_clr : '0)) | hw_event;
        end else if (wr_hit[i]) begin
          regs_q[i] <= apply_wstrb(regs_q[i], w_data, w_strb);
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[REG_BITS*i +: REG_BITS] = RO_MASK[i] ? hw_ro_in[REG_BITS*i +: REG_BITS] : regs_q[i];
    end
  end

  always_comb begin
    r_idx  = idx_of(64'(S_AXI.ARADDR));
    r_word = '0;
    r_resp = SLVERR;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (r_idx == i) begin
        r_resp = OKAY;
        r_word = RO_MASK[i] ? hw_ro_in[REG_BITS*i +: REG_BITS] : regs_q[i];
      end
    end
    ar_hs     = S_AXI.ARVALID && arready_q;
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (S_AXI.RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) begin
        rdata_q <= r_word;
        rresp_q <= r_resp;
      end
    end
  end

  assign S_AXI.ARREADY = arready_q;
  assign S_AXI.RVALID  = (r_state_q == R_DATA);
  assign S_AXI.RDATA   = rdata_q;
  assign S_AXI.RRESP   = rresp_q;

`ifdef IMGPROC_REGBANK_IRQ_EN
  localparam int unsigned IRQ_IDX = STATUS_IDX - 1;

  if (STATUS_IDX < 1) begin : g_bad_irq_idx
    $error("imgproc_axil_regbank: IRQ_ENABLE needs STATUS_IDX >= 1");
  end else if (RO_MASK[IRQ_IDX]) begin : g_bad_irq_ro
    $error("imgproc_axil_regbank: IRQ_ENABLE register must not be read-only");
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) irq <= 1'b0;
    else          irq <= |(regs_q[STATUS_IDX] & regs_q[IRQ_IDX]);
  end
`endif

endmodule

// File: tb/tb_imgproc_axil_regbank.sv
// Scoreboard bench for imgproc_axil_regbank (NUM_REGS=8, reg 5 read-only, status at reg 7).
module tb_imgproc_axil_regbank;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned RO_IDX = 5;
  localparam int unsigned ST_IDX = 7;
  localparam logic [1:0]  R_OK   = 2'b00;
  localparam logic [1:0]  R_ERR  = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic [NREGS*32-1:0]   reg_q;
  logic [NREGS-1:0]      reg_wr_stb;
  logic [NREGS*32-1:0]   hw_ro_in;
  logic [31:0]           hw_event;
`ifdef IMGPROC_REGBANK_IRQ_EN
  logic                  irq;
`endif

  imgproc_axil_regbank_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) s_axi ();

  imgproc_axil_regbank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .NUM_REGS           (NREGS),
    .RO_MASK            (8'h20),
    .STATUS_IDX         (ST_IDX)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .S_AXI      (s_axi),
    .reg_q      (reg_q),
    .reg_wr_stb (reg_wr_stb),
    .hw_ro_in   (hw_ro_in),
    .hw_event   (hw_event)
`ifdef IMGPROC_REGBANK_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  logic [1:0]  b_exp_q [$];
  r_exp_t      r_exp_q [$];

  logic [31:0] mdl [NREGS];
  logic [31:0] stat_mdl;
  logic [31:0] ro_val;
  int unsigned exp_stb [NREGS];
  int unsigned stb_cnt [NREGS];
  logic        bv_prev = 1'b0;
  int unsigned b_rise_cyc = 0;
  int unsigned last_aw_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (s_axi.BVALID && s_axi.BREADY) begin
        if (b_exp_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", 32'(s_axi.BRESP), 32'(b_exp_q.pop_front()));
      end
      if (s_axi.RVALID && s_axi.RREADY) begin
        if (r_exp_q.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          check("rresp", 32'(s_axi.RRESP), 32'(r_exp_q[0].resp));
          check("rdata", s_axi.RDATA, r_exp_q[0].data);
          void'(r_exp_q.pop_front());
        end
      end
      for (int i = 0; i < int'(NREGS); i++) if (reg_wr_stb[i]) stb_cnt[i] <= stb_cnt[i] + 1;
      if (s_axi.BVALID && !bv_prev) b_rise_cyc <= cyc;
    end
    bv_prev <= s_axi.BVALID;
  end

  task automatic wait_b_drain();
    int unsigned n = 0;
    while (b_exp_q.size() != 0 && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (b_exp_q.size() != 0) check("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned w_lead, input logic [31:0] ev, input bit wait_resp);
    int unsigned idx;
    logic [31:0] m;
    bit aw_done, w_done, aw_hs, w_hs;
    int unsigned n;
    idx = 32'(addr[5:2]);
    m   = strb_mask(strb);
    if (idx >= NREGS) b_exp_q.push_back(R_ERR);
    else begin
      b_exp_q.push_back(R_OK);
      if (idx == ST_IDX) stat_mdl = stat_mdl & ~(data & m);
      else if (idx != RO_IDX) mdl[idx] = (mdl[idx] & ~m) | (data & m);
      if (idx != RO_IDX) exp_stb[idx]++;
    end
    stat_mdl = stat_mdl | ev;
    s_axi.AWADDR  = addr;
    s_axi.WDATA   = data;
    s_axi.WSTRB   = strb;
    s_axi.WVALID  = 1'b1;
    s_axi.AWVALID = (w_lead == 0);
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      @(negedge ACLK);
      aw_hs = s_axi.AWVALID && s_axi.AWREADY;
      w_hs  = s_axi.WVALID && s_axi.WREADY;
      @(posedge ACLK); #1;
      n++;
      if (aw_hs) begin s_axi.AWVALID = 1'b0; aw_done = 1'b1; last_aw_cyc = cyc; end
      if (w_hs) begin s_axi.WVALID = 1'b0; w_done = 1'b1; end
      if (!aw_done && n >= w_lead) s_axi.AWVALID = 1'b1;
    end
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'd0, 32'd1);
    if (ev != 0) begin
      hw_event = ev;
      @(posedge ACLK); #1;
      hw_event = '0;
    end
    if (wait_resp) wait_b_drain();
  endtask

  task automatic axi_read(input logic [5:0] addr);
    int unsigned idx;
    bit done;
    int unsigned n;
    idx = 32'(addr[5:2]);
    if (idx >= NREGS)       r_exp_q.push_back('{data: 32'h0, resp: R_ERR});
    else if (idx == RO_IDX) r_exp_q.push_back('{data: ro_val, resp: R_OK});
    else if (idx == ST_IDX) r_exp_q.push_back('{data: stat_mdl, resp: R_OK});
    else                    r_exp_q.push_back('{data: mdl[idx], resp: R_OK});
    s_axi.ARADDR  = addr;
    s_axi.ARVALID = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 100) begin
      @(negedge ACLK);
      done = s_axi.ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    s_axi.ARVALID = 1'b0;
    if (!done) check("rd_handshake_timeout", 32'd0, 32'd1);
    n = 0;
    while (r_exp_q.size() != 0 && n < 100) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (r_exp_q.size() != 0) check("r_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bv_cnt;
    s_axi.AWADDR = '0; s_axi.AWPROT = 3'b010; s_axi.AWVALID = 1'b0;
    s_axi.WDATA = '0; s_axi.WSTRB = '0; s_axi.WVALID = 1'b0;
    s_axi.BREADY = 1'b1;
    s_axi.ARADDR = '0; s_axi.ARPROT = 3'b101; s_axi.ARVALID = 1'b0;
    s_axi.RREADY = 1'b1;
    hw_event = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      hw_ro_in[32*i +: 32] = 32'h0BAD0000 + 32'(i);
      mdl[i] = '0; exp_stb[i] = 0; stb_cnt[i] = 0;
    end
    ro_val = 32'hCAFE0001;
    hw_ro_in[32*RO_IDX +: 32] = ro_val;
    stat_mdl = '0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(s_axi.AWREADY), 32'd0);
    check("rst_wready",  32'(s_axi.WREADY),  32'd0);
    check("rst_arready", 32'(s_axi.ARREADY), 32'd0);
    check("rst_bvalid",  32'(s_axi.BVALID),  32'd0);
    check("rst_rvalid",  32'(s_axi.RVALID),  32'd0);
    check("rst_stb",     32'(reg_wr_stb),    32'd0);
    check("rst_rdata",   s_axi.RDATA,        32'd0);
    check("rst_resp",    32'({s_axi.BRESP, s_axi.RRESP}), 32'd0);
    check("rst_reg0",    reg_q[31:0],        32'd0);
    check("rst_status",  reg_q[32*ST_IDX +: 32], 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_awready", 32'(s_axi.AWREADY), 32'd1);
    check("post_rst_arready", 32'(s_axi.ARREADY), 32'd1);

    // basic write/read-back and strobe pulses
    for (int i = 0; i < 4; i++) axi_write(6'(4*i), 32'(i + 1), 4'hF, 0, '0, 1'b1);
    for (int i = 0; i < 4; i++) axi_read(6'(4*i));
    for (int i = 0; i < 4; i++) check("stb_once", 32'(stb_cnt[i]), 32'd1);

    // W ahead of AW, partial strobes
    axi_write(6'h08, 32'h11223344, 4'hF, 0, '0, 1'b1);
    axi_write(6'h08, 32'hDEADBEEF, 4'b0101, 3, '0, 1'b1);
    check("b_latency", 32'(b_rise_cyc - last_aw_cyc), 32'd1);
    axi_read(6'h08);
    check("merge_reg_q", reg_q[32*2 +: 32], 32'h11AD33EF);

    // read-only register
    axi_write(6'h14, 32'hFFFFFFFF, 4'hF, 0, '0, 1'b1);
    axi_read(6'h14);
    check("ro_no_stb", 32'(stb_cnt[RO_IDX]), 32'd0);

    // W1C status with concurrent hardware set
    hw_event = 32'h5;
    @(posedge ACLK); #1;
    hw_event = '0;
    stat_mdl = stat_mdl | 32'h5;
    axi_read(6'h1C);
    axi_write(6'h1C, 32'h1, 4'hF, 0, 32'h1, 1'b1);
    axi_read(6'h1C);
    axi_write(6'h1C, 32'h4, 4'hF, 0, '0, 1'b1);
    axi_read(6'h1C);

    // out-of-range decode and back-pressured response
    axi_write(6'h3C, 32'h12345678, 4'hF, 0, '0, 1'b1);
    axi_read(6'h3C);
    for (int i = 0; i < int'(NREGS); i++) axi_read(6'(4*i));
    s_axi.BREADY = 1'b0;
    axi_write(6'h3C, 32'h87654321, 4'hF, 0, '0, 1'b0);
    repeat (10) @(posedge ACLK);
    #1;
    check("bvalid_held", 32'(s_axi.BVALID), 32'd1);
    axi_write(6'h00, 32'hA5A5A5A5, 4'hF, 0, '0, 1'b0);
    @(negedge ACLK);
    check("awready_blocked", 32'(s_axi.AWREADY), 32'd0);
    check("bvalid_still",    32'(s_axi.BVALID),  32'd1);
    @(posedge ACLK); #1;
    s_axi.BREADY = 1'b1;
    wait_b_drain();
    axi_read(6'h00);

`ifdef IMGPROC_REGBANK_IRQ_EN
    axi_write(6'h18, 32'h4, 4'hF, 0, '0, 1'b1);
    check("irq_idle", 32'(irq), 32'd0);
    hw_event = 32'h4;
    @(posedge ACLK); #1;
    hw_event = '0;
    stat_mdl = stat_mdl | 32'h4;
    @(negedge ACLK);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge ACLK);
    check("irq_set", 32'(irq), 32'd1);
    axi_write(6'h1C, 32'h4, 4'hF, 0, '0, 1'b1);
    check("irq_clr", 32'(irq), 32'd0);
`endif

    // reset with AW captured and W never presented
    @(posedge ACLK); #1;
    s_axi.AWADDR  = 6'h04;
    s_axi.AWVALID = 1'b1;
    @(negedge ACLK);
    check("mid_aw_ready", 32'(s_axi.AWREADY), 32'd1);
    @(posedge ACLK); #1;
    s_axi.AWVALID = 1'b0;
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    for (int i = 0; i < int'(NREGS); i++) mdl[i] = '0;
    stat_mdl = '0;
    bv_cnt = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (s_axi.BVALID) bv_cnt++;
    end
    check("rst_no_bvalid", 32'(bv_cnt), 32'd0);
`ifdef IMGPROC_REGBANK_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    axi_read(6'h00);
    axi_read(6'h04);
    axi_read(6'h1C);

    for (int i = 0; i < int'(NREGS); i++) check("stb_total", 32'(stb_cnt[i]), 32'(exp_stb[i]));
    check("b_queue_empty", 32'(b_exp_q.size()), 32'd0);
    check("r_queue_empty", 32'(r_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
